// File: rtl/cpu_types_pkg.sv
// Shared MIPS types: opcodes, functs, ALU ops, control-unit states
// and the datapath mux select encodings.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0a,
        OP_SLTIU = 6'h0b,
        OP_ANDI  = 6'h0c,
        OP_ORI   = 6'h0d,
        OP_XORI  = 6'h0e,
        OP_LUI   = 6'h0f,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b,
        OP_HALT  = 6'h3f
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2a,
        FN_SLTU = 6'h2b
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } cu_state_t;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    localparam logic [1:0] RD_RD  = 2'b00;
    localparam logic [1:0] RD_RT  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    localparam logic [2:0] PB_REG   = 3'd0;
    localparam logic [2:0] PB_IMM   = 3'd1;
    localparam logic [2:0] PB_SHAMT = 3'd2;

endpackage

// File: rtl/multicycle_control_unit_decode.sv
// control_decode: combinational opcode/funct -> static datapath controls
// and class bits. Ports: opcode, funct in; mux/ALU selects, class bits out.
module control_decode
    import cpu_types_pkg::*;
(
    input  opcode_t    opcode,
    input  funct_t     funct,
    output aluop_t     alu_op,
    output logic [2:0] portb_src,
    output logic       ext_src,
    output logic       lui_src,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] jump_sel,
    output logic       is_mem,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_bne,
    output logic       is_jump,
    output logic       writes_reg,
    output logic       ovf_op
);

    always_comb begin
        alu_op     = ALU_SLL;
        portb_src  = PB_REG;
        ext_src    = 1'b0;
        lui_src    = 1'b0;
        reg_dst    = RD_RD;
        mem_to_reg = M2R_ALU;
        jump_sel   = PC_PLUS4;
        is_mem     = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_bne     = 1'b0;
        is_jump    = 1'b0;
        writes_reg = 1'b0;
        ovf_op     = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                writes_reg = 1'b1;
                unique case (funct)
                    FN_ADD:  begin alu_op = ALU_ADD; ovf_op = 1'b1; end
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB:  begin alu_op = ALU_SUB; ovf_op = 1'b1; end
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SLL:  begin alu_op = ALU_SLL; portb_src = PB_SHAMT; end
                    FN_SRL:  begin alu_op = ALU_SRL; portb_src = PB_SHAMT; end
                    FN_JR: begin
                        writes_reg = 1'b0;
                        is_jump    = 1'b1;
                        jump_sel   = PC_REG;
                    end
                    // unknown funct retires as a NOP
                    default: writes_reg = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                writes_reg = 1'b1;
                portb_src  = PB_IMM;
                ext_src    = 1'b1;
                reg_dst    = RD_RT;
                ovf_op     = (opcode == OP_ADDI);
                alu_op     = (opcode == OP_SLTI)  ? ALU_SLT :
                             (opcode == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                writes_reg = 1'b1;
                portb_src  = PB_IMM;
                reg_dst    = RD_RT;
                alu_op     = (opcode == OP_ANDI) ? ALU_AND :
                             (opcode == OP_ORI)  ? ALU_OR : ALU_XOR;
            end
            OP_LUI: begin
                writes_reg = 1'b1;
                portb_src  = PB_IMM;
                lui_src    = 1'b1;
                reg_dst    = RD_RT;
                alu_op     = ALU_OR;
            end
            OP_LW, OP_SW: begin
                is_mem     = 1'b1;
                is_store   = (opcode == OP_SW);
                writes_reg = (opcode == OP_LW);
                portb_src  = PB_IMM;
                ext_src    = 1'b1;
                reg_dst    = RD_RT;
                mem_to_reg = M2R_MEM;
                alu_op     = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                is_branch = 1'b1;
                is_bne    = (opcode == OP_BNE);
                ext_src   = 1'b1;
                alu_op    = ALU_SUB;
            end
            OP_J: begin
                is_jump  = 1'b1;
                jump_sel = PC_JUMP;
            end
            OP_JAL: begin
                is_jump    = 1'b1;
                jump_sel   = PC_JUMP;
                writes_reg = 1'b1;
                reg_dst    = RD_R31;
                mem_to_reg = M2R_PC4;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with memory-wait watchdog. Inputs: CLK, RST,
// opcode/funct, ALU flags, ihit/dhit. Outputs: datapath controls, commit
// strobes, halt and sticky fault flags, debug state. Optional overflow
// trap is enabled with `define OVERFLOW_TRAP_EN.
module multicycle_control_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT_W   = 8,
    parameter int unsigned TIMEOUT_MAX = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  opcode_t    opcode,
    input  funct_t     funct,
    input  logic       Zero,
    input  logic       Overflow,
    input  logic       ihit,
    input  logic       dhit,
    output logic       iREN,
    output logic       IR_WEN,
    output logic [1:0] PC_src,
    output logic       Ext_src,
    output logic       LUI_src,
    output logic [2:0] portb_src,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output aluop_t     ALU_op,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWEN,
    output logic       PC_EN,
    output logic       halt,
    output logic       mem_timeout,
    output logic       ovf_trap,
    output cu_state_t  state
);

    localparam logic [TIMEOUT_W-1:0] TMAX = TIMEOUT_W'(TIMEOUT_MAX);

    aluop_t     d_alu;
    logic [2:0] d_portb;
    logic [1:0] d_rdst, d_m2r, d_jsel;
    logic       d_ext, d_lui, d_mem, d_store, d_br, d_bne;
    logic       d_jump, d_wr, d_ovf;

    logic [TIMEOUT_W-1:0] wait_cnt, wait_inc;
    logic wait_expired, take_br, ovf_q, ovf_hit, alu_stage, in_wb;

    control_decode u_decode (
        .opcode     (opcode),
        .funct      (funct),
        .alu_op     (d_alu),
        .portb_src  (d_portb),
        .ext_src    (d_ext),
        .lui_src    (d_lui),
        .reg_dst    (d_rdst),
        .mem_to_reg (d_m2r),
        .jump_sel   (d_jsel),
        .is_mem     (d_mem),
        .is_store   (d_store),
        .is_branch  (d_br),
        .is_bne     (d_bne),
        .is_jump    (d_jump),
        .writes_reg (d_wr),
        .ovf_op     (d_ovf)
    );

`ifdef OVERFLOW_TRAP_EN
    assign ovf_hit = d_ovf & Overflow;
`else
    logic unused_ovf;
    assign unused_ovf = d_ovf | Overflow;
    assign ovf_hit    = 1'b0;
`endif

    // saturating: never wraps past TMAX
    assign wait_inc = (wait_cnt == TMAX) ? wait_cnt
                                         : wait_cnt + TIMEOUT_W'(1);
    // this miss is the one that brings the count to TMAX
    assign wait_expired = (wait_inc == TMAX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= FETCH;
            wait_cnt    <= '0;
            take_br     <= 1'b0;
            mem_timeout <= 1'b0;
            ovf_q       <= 1'b0;
            PC_EN       <= 1'b0;
            RegWEN      <= 1'b0;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
        end else begin
            PC_EN  <= 1'b0;
            RegWEN <= 1'b0;
            unique case (state)
                FETCH: begin
                    if (ihit) begin
                        state <= DECODE;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_expired) begin
                            state       <= HALT;
                            mem_timeout <= 1'b1;
                        end
                    end
                end
                DECODE: state <= (opcode == OP_HALT) ? HALT : EXEC;
                EXEC: begin
                    take_br <= d_br & (d_bne ? !Zero : Zero);
                    if (ovf_hit) begin
                        state <= HALT;
                        ovf_q <= 1'b1;
                    end else if (d_mem) begin
                        state    <= MEM;
                        wait_cnt <= '0;
                        MemRead  <= !d_store;
                        MemWrite <= d_store;
                    end else begin
                        state  <= WB;
                        PC_EN  <= 1'b1;
                        RegWEN <= d_wr;
                    end
                end
                MEM: begin
                    if (dhit) begin
                        state    <= WB;
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        PC_EN    <= 1'b1;
                        RegWEN   <= d_wr;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_expired) begin
                            state       <= HALT;
                            mem_timeout <= 1'b1;
                            MemRead     <= 1'b0;
                            MemWrite    <= 1'b0;
                        end
                    end
                end
                WB: begin
                    state    <= FETCH;
                    wait_cnt <= '0;
                end
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

    assign iREN     = (state == FETCH);
    assign IR_WEN   = (state == FETCH) & ihit;
    assign halt     = (state == HALT);
    assign ovf_trap = ovf_q;

    assign alu_stage = (state inside {EXEC, MEM, WB});
    assign in_wb     = (state == WB);

    assign ALU_op    = alu_stage ? d_alu   : ALU_SLL;
    assign portb_src = alu_stage ? d_portb : PB_REG;
    assign Ext_src   = alu_stage & d_ext;
    assign LUI_src   = alu_stage & d_lui;

    assign RegDst   = in_wb ? d_rdst : RD_RD;
    assign MemtoReg = in_wb ? d_m2r  : M2R_ALU;
    assign PC_src   = !in_wb            ? PC_PLUS4  :
                      d_jump            ? d_jsel    :
                      (d_br & take_br)  ? PC_BRANCH : PC_PLUS4;

endmodule
